multicycle_ctrl: RTL and testbench

- Multicycle main controller for the ARM-subset core.
- Decodes the instruction register's `op`/`funct`/`rd` fields and sequences each instruction through a Moore state machine.
- Drives the datapath mux selects and the raw `pcs`/`reg_w`/`mem_w`/`flag_w`/`no_write` strobes that the conditional-execution logic gates with the condition check.
- Sits between the instruction register and the condition logic; the condition logic owns flag storage and the final write enables.

---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: sequences each instruction through a Moore FSM and
// drives the datapath mux selects plus the raw write strobes for the condition logic.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    // ALU command decode: {known, sets_cv, is_cmp, alu_control[1:0]}
    function automatic logic [4:0] alu_decode(input logic [3:0] cmd);
        logic [4:0] res;
        case (cmd)
            4'b0100: res = {1'b1, 1'b1, 1'b0, 2'b00};
            4'b0010: res = {1'b1, 1'b1, 1'b0, 2'b01};
            4'b0000: res = {1'b1, 1'b0, 1'b0, 2'b10};
            4'b1100: res = {1'b1, 1'b0, 1'b0, 2'b11};
            4'b1010: res = {1'b1, 1'b1, 1'b1, 2'b01};
            default: res = {1'b0, 1'b0, 1'b0, 2'b00};
        endcase
        return res;
    endfunction

    logic [4:0] dec_s;
    logic       ir_write_s;
    logic       next_pc_s;
    logic       reg_w_s;
    logic       mem_w_s;
    logic       branch_s;
    logic       alu_op_s;
    logic [1:0] flag_w_s;
    logic       no_write_s;

    // Next-state selection
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state Moore outputs; strobes are masked while reset is held
    always_comb begin
        ir_write_s  = 1'b0;
        next_pc_s   = 1'b0;
        reg_w_s     = 1'b0;
        mem_w_s     = 1'b0;
        branch_s    = 1'b0;
        alu_op_s    = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        flag_w_s    = 2'b00;
        no_write_s  = 1'b0;
        dec_s       = alu_decode(funct[4:1]);
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_s = 1'b1;
                next_pc_s  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w_s    = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w_s = 1'b1;
            end
            S_EXECR:  alu_op_s = 1'b1;
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_op_s  = 1'b1;
            end
            S_ALUWB:  reg_w_s = 1'b1;
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch_s   = 1'b1;
            end
            default: ;
        endcase
        // no_write spans the execute and writeback states so CMP never writes
        if (alu_op_s) begin
            alu_control = dec_s[1:0];
            flag_w_s    = dec_s[4] ? {funct[0], funct[0] & dec_s[3]} : 2'b00;
            no_write_s  = dec_s[2];
        end else if (state_q == S_ALUWB) begin
            no_write_s  = dec_s[2];
        end else begin
            no_write_s  = 1'b0;
        end
        ir_write = ir_write_s & ~reset;
        next_pc  = next_pc_s & ~reset;
        reg_w    = reg_w_s & ~reset;
        mem_w    = mem_w_s & ~reset;
        pcs      = (branch_s | (reg_w_s & (rd == 4'hF))) & ~reset;
        flag_w   = reset ? 2'b00 : flag_w_s;
        no_write = no_write_s & ~reset;
    end

    assign imm_src = op;
    assign reg_src = {(op == 2'b01), (op == 2'b10)};
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output vectors compared
// against an instruction-level reference model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [3:0] rd = 4'd0;
    logic       ir_write, next_pc, adr_src, alu_src_a, pcs, reg_w, mem_w, no_write;
    logic [1:0] alu_src_b, result_src, alu_control, imm_src, reg_src, flag_w;
    logic [3:0] state;

    int tests_run = 0;
    int failures  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
        .ir_write(ir_write), .next_pc(next_pc), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .flag_w(flag_w),
        .no_write(no_write), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] observed();
        return {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
                alu_control, imm_src, reg_src, pcs, reg_w, mem_w, flag_w,
                no_write, state};
    endfunction

    // Expected outputs of one instruction while it sits in state s
    function automatic logic [23:0] exp_vec(input logic [1:0] o, input logic [5:0] f,
                                            input logic [3:0] r, input int s, input bit rst);
        logic       ir, np, adr, a, regw, memw, p, nw, exec, known, arith, is_cmp;
        logic [1:0] b, res, alu, alu_o, fw;
        logic [3:0] cmd;
        logic [3:0] s4;
        cmd    = f[4:1];
        known  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
                 (cmd == 4'b1100) || (cmd == 4'b1010);
        arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        is_cmp = (cmd == 4'b1010);
        alu    = (cmd == 4'b0010 || is_cmp) ? 2'b01 :
                 (cmd == 4'b0000) ? 2'b10 : (cmd == 4'b1100) ? 2'b11 : 2'b00;
        adr = 1'b0; a = 1'b0; b = 2'b00; res = 2'b00;
        case (s)
            0, 1:    begin a = 1'b1; b = 2'b10; res = 2'b10; end
            2:       b = 2'b01;
            3:       adr = 1'b1;
            4:       res = 2'b01;
            5:       adr = 1'b1;
            7:       b = 2'b01;
            9:       begin b = 2'b01; res = 2'b10; end
            default: ;
        endcase
        exec  = (s == 6) || (s == 7);
        ir    = (s == 0);
        np    = (s == 0);
        memw  = (s == 5);
        regw  = (s == 4) || (s == 8);
        alu_o = exec ? alu : 2'b00;
        fw    = (exec && known) ? {f[0], f[0] & arith} : 2'b00;
        nw    = (exec || s == 8) && is_cmp;
        p     = (s == 9) || (regw && r == 4'hF);
        if (rst) begin
            ir = 1'b0; np = 1'b0; memw = 1'b0; regw = 1'b0; p = 1'b0; fw = 2'b00; nw = 1'b0;
        end
        s4 = s[3:0];
        return {ir, np, adr, a, b, res, alu_o, o, (o == 2'b01), (o == 2'b10),
                p, regw, memw, fw, nw, s4};
    endfunction

    // Reference model: instruction class determines the visited states
    task automatic model_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        int seq[$];
        exp_q.delete();
        case (o)
            2'b00:   seq = '{0, 1, (f[5] ? 7 : 6), 8};
            2'b01:   seq = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10:   seq = '{0, 1, 9};
            default: seq = '{0, 1};
        endcase
        foreach (seq[i]) exp_q.push_back(exp_vec(o, f, r, seq[i], 1'b0));
        exp_q.push_back(exp_vec(o, f, r, 0, 1'b0));
    endtask

    // Drive one instruction from FETCH and record one vector per cycle plus the return state
    task automatic drive_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        obs_q.delete();
        op = o; funct = f; rd = r;
        for (int i = 0; i < exp_q.size() - 1; i++) begin
            @(negedge clk);
            obs_q.push_back(observed());
            @(posedge clk);
            #1;
        end
        obs_q.push_back(observed());
    endtask

    task automatic test_reset();
        op = 2'b01; funct = 6'b000001; rd = 4'hF;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 0, 1'b1)) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", observed(), exp_vec(op, funct, rd, 0, 1'b1));
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 0, 1'b0)) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", observed(), exp_vec(op, funct, rd, 0, 1'b0));
        end
    endtask

    task automatic test_dp();
        logic [5:0] fs[2] = '{6'b101000, 6'b010101};
        for (int k = 0; k < 2; k++) begin
            model_instr(2'b00, fs[k], 4'h3);
            drive_instr(2'b00, fs[k], 4'h3);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL dp funct=%b cyc%0d: got %h expected %h", fs[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_memory();
        logic [5:0] fs[2] = '{6'b011001, 6'b011000};
        logic [3:0] rs[2] = '{4'hF, 4'h2};
        for (int k = 0; k < 2; k++) begin
            model_instr(2'b01, fs[k], rs[k]);
            drive_instr(2'b01, fs[k], rs[k]);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL mem funct=%b cyc%0d: got %h expected %h", fs[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_branch_undef();
        logic [1:0] os[2] = '{2'b10, 2'b11};
        for (int k = 0; k < 2; k++) begin
            model_instr(os[k], 6'b110101, 4'hF);
            drive_instr(os[k], 6'b110101, 4'hF);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL br_undef op=%b cyc%0d: got %h expected %h", os[k], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        op = 2'b01; funct = 6'b000001; rd = 4'h7;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 4, 1'b0)) begin
            failures++;
            $display("FAIL async_pre: got %h expected %h", observed(), exp_vec(op, funct, rd, 4, 1'b0));
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 0, 1'b1)) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", observed(), exp_vec(op, funct, rd, 0, 1'b1));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 0, 1'b0)) begin
            failures++;
            $display("FAIL async_resume: got %h expected %h", observed(), exp_vec(op, funct, rd, 0, 1'b0));
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (observed() !== exp_vec(op, funct, rd, 1, 1'b0)) begin
            failures++;
            $display("FAIL async_decode: got %h expected %h", observed(), exp_vec(op, funct, rd, 1, 1'b0));
        end
        reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [5:0] f;
        logic [3:0] r;
        for (int k = 0; k < 60; k++) begin
            o = 2'($urandom_range(0, 3));
            f = 6'($urandom_range(0, 63));
            r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            model_instr(o, f, r);
            drive_instr(o, f, r);
            for (int i = 0; i < exp_q.size(); i++) begin
                tests_run++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand op=%b funct=%b rd=%h cyc%0d: got %h expected %h",
                             o, f, r, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_memory();
        test_branch_undef();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
